// File: rtl/neopixel_color_pipe.sv
// neopixel_color_pipe: brightness-scaling pipeline between the neopixel FIFO and the controller.
//
// The upstream side pops packed GRB pixels (G[23:16] R[15:8] B[7:0]) from a first-word-fall-through
// FIFO. Each pixel is scaled by a global brightness and presented again through an identical
// FWFT read port. Pixels handed out are counted per frame, and an end-of-frame pulse is produced.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   fifo_empty_i/fifo_data_i   upstream FIFO head (valid while !fifo_empty_i)
//   fifo_pop_o                 upstream pop; the head word is consumed in the same cycle
//   ctrl_empty_o/ctrl_data_o   processed pixel toward neopixel_controller
//   ctrl_pop_i                 controller consumes ctrl_data_o (ignored while ctrl_empty_o)
//   enable_i                   allow fetching new pixels
//   flush_i                    drop buffered pixels and clear the pixel counter
//   brightness_i               global brightness, 255 = unity
//   num_pixels_i               pixels per frame, 0 = free-running counter
//   pixel_cnt_o/frame_done_o   pixels handed out in this frame / 1-cycle end-of-frame pulse
//
// Build option: define NEOPIXEL_GAMMA_EN to add a registered per-channel gamma (2.2) ROM stage
// after scaling; latency grows from 2 to 3 cycles.
module neopixel_color_pipe #(
    parameter int NumChannels = 3,
    parameter int PixCntWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     fifo_empty_i,
    input  logic [8*NumChannels-1:0] fifo_data_i,
    output logic                     fifo_pop_o,
    output logic                     ctrl_empty_o,
    output logic [8*NumChannels-1:0] ctrl_data_o,
    input  logic                     ctrl_pop_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [7:0]               brightness_i,
    input  logic [PixCntWidth-1:0]   num_pixels_i,
    output logic [PixCntWidth-1:0]   pixel_cnt_o,
    output logic                     frame_done_o
);
    localparam int W = 8 * NumChannels;

    // out = (c * (b + 1)) >> 8; the product never exceeds 16 bits, so b=255 is exact.
    function automatic logic [W-1:0] scale(input logic [W-1:0] px, input logic [7:0] b);
        logic [W-1:0] r;
        logic [15:0]  p;
        r = '0;
        for (int c = 0; c < NumChannels; c++) begin
            p = {8'd0, px[8*c +: 8]} * ({8'd0, b} + 16'd1);
            r[8*c +: 8] = 8'(p >> 8);
        end
        return r;
    endfunction

    logic           s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
    logic [W-1:0]   s0_data_q, s0_data_d, s1_data_q, s1_data_d;
    logic           adv0, adv1, out_valid, out_pop, last_pix, frame_done_q, frame_done_d;
    logic [PixCntWidth-1:0] pixel_cnt_q, pixel_cnt_d;

`ifdef NEOPIXEL_GAMMA_EN
    typedef logic [7:0] lut_t [256];

    // g(i) = round(255 * (i/255)^2.2), evaluated at elaboration into a constant ROM.
    function automatic lut_t gamma_lut();
        lut_t g;
        for (int i = 0; i < 256; i++) begin
            g[i] = 8'($rtoi(255.0 * ((real'(i) / 255.0) ** 2.2) + 0.5));
        end
        return g;
    endfunction

    localparam lut_t GammaLut = gamma_lut();

    function automatic logic [W-1:0] gamma(input logic [W-1:0] px);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < NumChannels; c++) begin
            r[8*c +: 8] = GammaLut[px[8*c +: 8]];
        end
        return r;
    endfunction

    logic           s2_valid_q, s2_valid_d, adv2;
    logic [W-1:0]   s2_data_q, s2_data_d;

    assign adv2        = !s2_valid_q | ctrl_pop_i;
    assign adv1        = !s1_valid_q | adv2;
    assign out_valid   = s2_valid_q;
    assign ctrl_data_o = s2_data_q;

    always_comb begin
        s2_valid_d = flush_i ? 1'b0 : (adv2 ? s1_valid_q : s2_valid_q);
        s2_data_d  = (s1_valid_q & adv2) ? gamma(s1_data_q) : s2_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end
`else
    assign adv1        = !s1_valid_q | ctrl_pop_i;
    assign out_valid   = s1_valid_q;
    assign ctrl_data_o = s1_data_q;
`endif

    assign adv0         = !s0_valid_q | adv1;
    // Gated by rst_ni so a held reset never consumes upstream words.
    assign fifo_pop_o   = rst_ni & enable_i & !fifo_empty_i & adv0 & !flush_i;
    assign ctrl_empty_o = !out_valid;
    // flush_i wins over a simultaneous controller pop: that pop is neither counted nor flagged.
    assign out_pop      = ctrl_pop_i & out_valid & !flush_i;
    assign last_pix     = (num_pixels_i != '0) && (pixel_cnt_q == num_pixels_i - PixCntWidth'(1));
    assign pixel_cnt_o  = pixel_cnt_q;
    assign frame_done_o = frame_done_q;

    always_comb begin
        s0_valid_d   = flush_i ? 1'b0 : (adv0 ? fifo_pop_o : s0_valid_q);
        s0_data_d    = fifo_pop_o ? fifo_data_i : s0_data_q;
        s1_valid_d   = flush_i ? 1'b0 : (adv1 ? s0_valid_q : s1_valid_q);
        s1_data_d    = (s0_valid_q & adv1) ? scale(s0_data_q, brightness_i) : s1_data_q;
        pixel_cnt_d  = flush_i ? '0 : (out_pop ? (last_pix ? '0 : pixel_cnt_q + PixCntWidth'(1)) : pixel_cnt_q);
        frame_done_d = out_pop & last_pix;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s0_valid_q   <= 1'b0;
            s0_data_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            pixel_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_data_q    <= s0_data_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            pixel_cnt_q  <= pixel_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_neopixel_color_pipe.sv
// tb_neopixel_color_pipe: self-checking bench for neopixel_color_pipe with a FIFO model and scoreboard.
module tb_neopixel_color_pipe;
    localparam int W  = 24;
    localparam int PW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni, fifo_empty_i, fifo_pop_o, ctrl_empty_o, ctrl_pop_i;
    logic          enable_i, flush_i, frame_done_o;
    logic [W-1:0]  fifo_data_i, ctrl_data_o;
    logic [7:0]    brightness_i;
    logic [PW-1:0] num_pixels_i, pixel_cnt_o;

    always #5 clk_i = ~clk_i;

    neopixel_color_pipe #(.NumChannels(3), .PixCntWidth(PW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
        .ctrl_empty_o(ctrl_empty_o), .ctrl_data_o(ctrl_data_o), .ctrl_pop_i(ctrl_pop_i),
        .enable_i(enable_i), .flush_i(flush_i), .brightness_i(brightness_i),
        .num_pixels_i(num_pixels_i), .pixel_cnt_o(pixel_cnt_o), .frame_done_o(frame_done_o)
    );

    typedef struct {
        logic [23:0] word;
        logic [7:0]  b;
        logic [23:0] exp;
    } vec_t;

    vec_t          vecs [8];
    int            errs = 0, checks = 0, outs = 0, pops = 0, cyc = 0, last_lat = 0;
    logic [W-1:0]  src_q[$], src_exp_q[$], exp_q[$];
    int            pop_cyc_q[$], done_log[$];
    logic [PW-1:0] mcnt = '0;
    logic          mdone = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    function automatic logic [23:0] model(input logic [23:0] w, input logic [7:0] b);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) r[8*c +: 8] = 8'((int'(w[8*c +: 8]) * (int'(b) + 1)) / 256);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty_i = (src_q.size() == 0);
        fifo_data_i  = fifo_empty_i ? '0 : src_q[0];
    endtask

    task automatic push(input logic [23:0] w, input logic [23:0] e);
        src_q.push_back(w);
        src_exp_q.push_back(e);
        upd_fifo();
    endtask

    // One clock: sample at negedge, update scoreboard and counter model, drive after posedge.
    task automatic tick();
        logic          nd;
        logic [W-1:0]  tmp;
        @(negedge clk_i);
        check("pixel_cnt", 32'(pixel_cnt_o), 32'(mcnt));
        check("frame_done", 32'(frame_done_o), 32'(mdone));
        if (frame_done_o) done_log.push_back(outs);
        nd = 1'b0;
        if (!rst_ni || flush_i) begin
            exp_q.delete();
            pop_cyc_q.delete();
            mcnt = '0;
        end else if (ctrl_pop_i && !ctrl_empty_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_output: got 0x%0h, expected no pixel", ctrl_data_o);
            end else begin
                check("ctrl_data", 32'(ctrl_data_o), 32'(exp_q.pop_front()));
                last_lat = cyc - pop_cyc_q.pop_front();
            end
            outs++;
            if (num_pixels_i != '0 && mcnt == num_pixels_i - 16'd1) begin
                mcnt = '0;
                nd   = 1'b1;
            end else mcnt = mcnt + 16'd1;
        end
        if (fifo_pop_o) begin
            if (src_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL pop_when_empty: got pop, expected none");
            end else begin
                exp_q.push_back(src_exp_q.pop_front());
                tmp = src_q.pop_front();
                pop_cyc_q.push_back(cyc);
            end
            pops++;
        end
        mdone = nd;
        @(posedge clk_i);
        #1;
        upd_fifo();
    endtask

    task automatic wait_outs(input string nm, input int n, input int lim);
        int k = 0;
        while (outs < n && k < lim) begin
            tick();
            k++;
        end
        check(nm, 32'(outs >= n), 32'd1);
    endtask

    initial begin
        int base, p0, d0;
        logic [23:0] w;
        vecs[0] = '{24'h12AB7F, 8'd255, 24'h12AB7F};
        vecs[1] = '{24'hFF8001, 8'd127, 24'h7F4000};
        vecs[2] = '{24'hFFFFFF, 8'd0,   24'h000000};
        vecs[3] = '{24'h808080, 8'd127, 24'h404040};
        vecs[4] = '{24'h010203, 8'd255, 24'h010203};
        vecs[5] = '{24'hFF00FF, 8'd63,  24'h3F003F};
        vecs[6] = '{24'h64C819, 8'd199, 24'h4E9C13};
        vecs[7] = '{24'hFFFFFF, 8'd1,   24'h010101};

        rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b0; ctrl_pop_i = 1'b0;
        brightness_i = 8'd255; num_pixels_i = '0;
        push(24'hA5A5A5, 24'hA5A5A5);
        repeat (2) begin
            tick();
            check("reset_no_pop", 32'(fifo_pop_o), 32'd0);
            check("reset_empty", 32'(ctrl_empty_o), 32'd1);
            check("reset_data", 32'(ctrl_data_o), 32'd0);
            check("reset_cnt", 32'(pixel_cnt_o), 32'd0);
            check("reset_done", 32'(frame_done_o), 32'd0);
        end
        rst_ni = 1'b1; ctrl_pop_i = 1'b1;
        wait_outs("after_reset_out", 1, 10);

        for (int i = 0; i < 8; i++) begin
            brightness_i = vecs[i].b;
            push(vecs[i].word, vecs[i].exp);
            wait_outs("vec_out", outs + 1, 10);
            check("vec_latency", 32'(last_lat), 32'd2);
        end

        brightness_i = 8'd255;
        base = outs;
        for (int i = 0; i < 8; i++) begin
            w = 24'($urandom);
            push(w, w);
        end
        for (int k = 0; k < 60 && outs < base + 8; k++) begin
            ctrl_pop_i = ~ctrl_pop_i;
            tick();
        end
        check("toggle_count", 32'(outs), 32'(base + 8));

        ctrl_pop_i = 1'b0;
        p0 = pops;
        base = outs;
        for (int i = 0; i < 8; i++) push(24'h010101 * 24'(i + 1), 24'h010101 * 24'(i + 1));
        repeat (10) tick();
        check("stall_pops", 32'(pops - p0), 32'd2);
        check("stall_pop_low", 32'(fifo_pop_o), 32'd0);
        ctrl_pop_i = 1'b1;
        wait_outs("stall_drain", base + 8, 40);

        enable_i = 1'b0;
        p0 = pops;
        push(24'h0F0F0F, 24'h0F0F0F);
        repeat (5) tick();
        check("disable_no_pop", 32'(pops - p0), 32'd0);
        check("disable_empty", 32'(ctrl_empty_o), 32'd1);
        enable_i = 1'b1;
        wait_outs("enable_out", outs + 1, 10);

        ctrl_pop_i = 1'b0;
        base = outs;
        p0 = pops;
        push(24'h111111, 24'h111111);
        push(24'h222222, 24'h222222);
        repeat (4) tick();
        check("buffered_pops", 32'(pops - p0), 32'd2);
        enable_i = 1'b0; ctrl_pop_i = 1'b1;
        wait_outs("drain_disabled", base + 2, 10);
        enable_i = 1'b1;

        flush_i = 1'b1; tick(); flush_i = 1'b0;
        num_pixels_i = 16'd3;
        base = outs;
        d0 = done_log.size();
        for (int i = 0; i < 7; i++) push(24'h030303 * 24'(i), 24'h030303 * 24'(i));
        wait_outs("frame_out", base + 7, 30);
        check("frame_cnt_end", 32'(pixel_cnt_o), 32'd1);
        repeat (2) tick();
        check("frame_pulses", 32'(done_log.size() - d0), 32'd2);
        if (done_log.size() >= d0 + 2) begin
            check("frame_pulse1", 32'(done_log[d0]), 32'(base + 3));
            check("frame_pulse2", 32'(done_log[d0 + 1]), 32'(base + 6));
        end

        flush_i = 1'b1; tick(); flush_i = 1'b0;
        num_pixels_i = '0;
        base = outs;
        d0 = done_log.size();
        for (int i = 0; i < 5; i++) push(24'h102030, 24'h102030);
        wait_outs("free_out", base + 5, 30);
        repeat (2) tick();
        check("free_no_pulse", 32'(done_log.size() - d0), 32'd0);
        check("free_cnt", 32'(pixel_cnt_o), 32'd5);

        flush_i = 1'b1; tick(); flush_i = 1'b0;
        num_pixels_i = 16'd1;
        ctrl_pop_i = 1'b0;
        base = outs;
        push(24'hAAAAAA, 24'hAAAAAA);
        push(24'hBBBBBB, 24'hBBBBBB);
        push(24'hC0FFEE, 24'hC0FFEE);
        repeat (4) tick();
        check("flush_full", 32'(ctrl_empty_o), 32'd0);
        flush_i = 1'b1; ctrl_pop_i = 1'b1;
        tick();
        flush_i = 1'b0; ctrl_pop_i = 1'b0;
        check("flush_empty", 32'(ctrl_empty_o), 32'd1);
        check("flush_cnt", 32'(pixel_cnt_o), 32'd0);
        check("flush_done", 32'(frame_done_o), 32'd0);
        ctrl_pop_i = 1'b1;
        wait_outs("flush_next_out", base + 1, 10);
        check("flush_next_latency", 32'(last_lat), 32'd2);
        repeat (2) tick();

        check("src_drained", 32'(src_q.size()), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
